// File: rtl/cp_pkg.sv
// Shared definitions for the cyclic-prefix inserter/remover pair: framer state,
// size limits and the configuration clamping rules.
package cp_pkg;

  typedef enum logic {
    DISCARD = 1'b0,
    PASS    = 1'b1
  } cp_state_e;

  localparam int MIN_LOG2     = 3;
  localparam int MAX_LOG2_DEF = 11;
  localparam int CNT_W_DEF    = MAX_LOG2_DEF + 1;

  function automatic int clamp_log2(input int log2, input int max_log2);
    if (log2 < MIN_LOG2) return MIN_LOG2;
    if (log2 > max_log2) return max_log2;
    return log2;
  endfunction

  // A prefix can never be as long as the body it precedes.
  function automatic int clamp_cp(input int cp, input int log2);
    int n;
    n = 1 << log2;
    return (cp >= n) ? n - 1 : cp;
  endfunction

endpackage

// File: rtl/cyclic_prefix_remover_if.sv
// AXI4-Stream sample bus with source (master) and sink (slave) views.
interface cyclic_prefix_remover_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// One-deep AXI4-Stream output register; holds data/last while stalled and
// lets a new load replace a beat that drains in the same cycle.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  can_load,
  cyclic_prefix_remover_if.master m
);

  logic                  vld_q, vld_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign can_load = !vld_q || m.tready;

  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      last_d = ld_last;
      data_d = ld_data;
    end else if (m.tready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end

  assign m.tvalid = vld_q;
  assign m.tlast  = last_q;
  assign m.tdata  = data_q;

endmodule

// File: rtl/cyclic_prefix_remover.sv
// Strips the cyclic prefix from each OFDM symbol and forwards the N body
// samples with TLAST on the last one; checks input TLAST framing.
module cyclic_prefix_remover
  import cp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOG2   = MAX_LOG2_DEF,
  parameter int CNT_W      = MAX_LOG2 + 1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [3:0]       cfg_fft_len_log2,
  input  logic [CNT_W-1:0] cfg_cp_len,
  cyclic_prefix_remover_if.slave  s_axis,
  cyclic_prefix_remover_if.master m_axis,
  output logic [15:0]      sym_count,
  output logic             err_tlast
);

  cp_state_e        state_q, state_d, cur_state, start_state;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cp_q, cp_d, cfg_cp_c, cur_cp, n_last;
  logic [3:0]       log2_q, log2_d, cfg_log2_c, cur_log2;
  logic [15:0]      sym_q, sym_d;
  logic             err_q, err_d;
  logic             can_load, load, ld_last, s_ready, in_xfer, restart;

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk      (ACLK),
    .rst      (ARESET),
    .load     (load),
    .ld_data  (s_axis.tdata),
    .ld_last  (ld_last),
    .can_load (can_load),
    .m        (m_axis)
  );

  // start_q marks the first cycle after reset: the live config is used
  // directly so the first symbol needs no extra latch cycle.
  always_comb begin
    cfg_log2_c  = 4'(clamp_log2(int'(cfg_fft_len_log2), MAX_LOG2));
    cfg_cp_c    = CNT_W'(clamp_cp(int'(cfg_cp_len), int'(cfg_log2_c)));
    start_state = (cfg_cp_c == '0) ? PASS : DISCARD;
    cur_log2    = start_q ? cfg_log2_c : log2_q;
    cur_cp      = start_q ? cfg_cp_c : cp_q;
    cur_state   = start_q ? start_state : state_q;
    n_last      = (CNT_W'(1) << cur_log2) - 1'b1;

    s_ready = !ARESET && ((cur_state == DISCARD) || can_load);
    in_xfer = s_axis.tvalid && s_ready;

    state_d = cur_state;
    cnt_d   = cnt_q;
    log2_d  = cur_log2;
    cp_d    = cur_cp;
    start_d = 1'b0;
    sym_d   = sym_q;
    err_d   = 1'b0;
    load    = 1'b0;
    ld_last = 1'b0;
    restart = 1'b0;

    if (in_xfer) begin
      if (cur_state == DISCARD) begin
        if (s_axis.tlast) begin
          err_d   = 1'b1;
          restart = 1'b1;
        end else if (cnt_q == cur_cp - 1'b1) begin
          state_d = PASS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        load = 1'b1;
        if (cnt_q == n_last) begin
          ld_last = 1'b1;
          err_d   = !s_axis.tlast;
          sym_d   = sym_q + 16'd1;
          restart = 1'b1;
        end else if (s_axis.tlast) begin
          // Early TLAST still closes the partial symbol downstream.
          ld_last = 1'b1;
          err_d   = 1'b1;
          restart = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    if (restart) begin
      cnt_d   = '0;
      log2_d  = cfg_log2_c;
      cp_d    = cfg_cp_c;
      state_d = start_state;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      start_q <= 1'b1;
      state_q <= DISCARD;
      cnt_q   <= '0;
      log2_q  <= 4'(MIN_LOG2);
      cp_q    <= '0;
      sym_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      log2_q  <= log2_d;
      cp_q    <= cp_d;
      sym_q   <= sym_d;
      err_q   <= err_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign sym_count     = sym_q;
  assign err_tlast     = err_q;

endmodule

// File: tb/tb_cyclic_prefix_remover.sv
// Testbench for cyclic_prefix_remover: directed and randomized symbols checked
// against a position-in-symbol reference model.
module tb_cyclic_prefix_remover;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_log2;
  logic [11:0] cfg_cp;
  logic [15:0] sym_count;
  logic        err_tlast;

  cyclic_prefix_remover_if #(.DATA_WIDTH(32)) s_if ();
  cyclic_prefix_remover_if #(.DATA_WIDTH(32)) m_if ();

  cyclic_prefix_remover #(.DATA_WIDTH(32), .MAX_LOG2(11), .CNT_W(12)) dut (
    .ACLK             (clk),
    .ARESET           (rst),
    .cfg_fft_len_log2 (cfg_log2),
    .cfg_cp_len       (cfg_cp),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .sym_count        (sym_count),
    .err_tlast        (err_tlast)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic l; int lg; int cp; } xfer_t;
  typedef struct { logic [31:0] d; logic l; } beat_t;

  xfer_t xlog[$];
  beat_t got_q[$];
  beat_t exp_q[$];

  int checks = 0, failures = 0;
  int err_seen = 0, stall_viol = 0;
  int exp_err, exp_sym, timeouts;
  int base_got, base_err, base_stall;
  int rdy_mode = 0, gap_pct = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = (m_if.tready === 1'b1) ? 1'b0 : 1'b1;
      default: m_if.tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (m_if.tvalid && m_if.tready) got_q.push_back('{m_if.tdata, m_if.tlast});
      if (err_tlast) err_seen++;
      if (prev_stall && !(m_if.tvalid && m_if.tdata == prev_d && m_if.tlast == prev_l))
        stall_viol++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_d     = m_if.tdata;
      prev_l     = m_if.tlast;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int lg, input int cp);
    @(posedge clk); #1;
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
    cfg_log2 = 4'(lg);
    cfg_cp   = 12'(cp);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    xlog.delete();
    base_got = got_q.size(); base_err = err_seen; base_stall = stall_viol;
    timeouts = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int  g, w;
    bit  done;
    g = 0;
    while (gap_pct > 0 && g < 4 && $urandom_range(0, 99) < gap_pct) begin
      s_if.tvalid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = l;
    done = 0; w = 0;
    while (!done) begin
      @(negedge clk);
      if (s_if.tready) begin
        xlog.push_back('{d, l, int'(cfg_log2), int'(cfg_cp)});
        done = 1;
      end else if (++w > 3000) begin
        timeouts++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
  endtask

  task automatic send_seq(input int first, input int len, input int last_at);
    for (int k = 0; k < len; k++) send(32'(first + k), k == last_at);
  endtask

  function automatic void sym_cfg(input int lg, input int cp, output int n, output int c);
    int l;
    l = (lg < 3) ? 3 : ((lg > 11) ? 11 : lg);
    n = 1 << l;
    c = (cp >= n) ? n - 1 : cp;
  endfunction

  // Walk each accepted input through its position in the current symbol.
  task automatic run_model();
    int pos, n, c, body;
    bit restart;
    exp_q.delete(); exp_err = 0; exp_sym = 0; pos = 0; n = 8; c = 0;
    foreach (xlog[i]) begin
      if (i == 0) sym_cfg(xlog[i].lg, xlog[i].cp, n, c);
      restart = 0;
      if (pos < c) begin
        if (xlog[i].l) begin exp_err++; restart = 1; end
        else pos++;
      end else begin
        body = pos - c;
        exp_q.push_back('{xlog[i].d, (body == n - 1) || xlog[i].l});
        if (body == n - 1) begin
          if (!xlog[i].l) exp_err++;
          exp_sym++;
          restart = 1;
        end else if (xlog[i].l) begin
          exp_err++;
          restart = 1;
        end else pos++;
      end
      if (restart) begin
        pos = 0;
        sym_cfg(xlog[i].lg, xlog[i].cp, n, c);
      end
    end
  endtask

  task automatic finish_scn(input string tag);
    int w, ng;
    run_model();
    w = 0;
    while (got_q.size() - base_got < exp_q.size() && w < 10000) begin
      @(posedge clk); w++;
    end
    repeat (4) @(posedge clk);
    #1;
    ng = got_q.size() - base_got;
    chk({tag, "_count"}, 64'(ng), 64'(exp_q.size()));
    for (int i = 0; i < ng && i < exp_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(got_q[base_got + i].d), 64'(exp_q[i].d));
      chk($sformatf("%s_last%0d", tag, i), 64'(got_q[base_got + i].l), 64'(exp_q[i].l));
    end
    chk({tag, "_sym_count"}, 64'(sym_count), 64'(16'(exp_sym)));
    chk({tag, "_err_pulses"}, 64'(err_seen - base_err), 64'(exp_err));
    chk({tag, "_stall_hold"}, 64'(stall_viol - base_stall), 64'd0);
    chk({tag, "_timeouts"}, 64'(timeouts), 64'd0);
  endtask

  initial begin
    int lg, cp, n, c, len, r, at;
    rst = 1'b1;
    cfg_log2 = 4'd3; cfg_cp = 12'd2;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tlast",  64'(m_if.tlast),  64'd0);
    chk("rst_m_tdata",  64'(m_if.tdata),  64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
    chk("rst_sym_count", 64'(sym_count), 64'd0);
    chk("rst_err_tlast", 64'(err_tlast), 64'd0);

    // Frame strip, then the same frame under alternating backpressure.
    rdy_mode = 0; gap_pct = 0;
    do_reset(3, 2);
    send_seq(1, 10, 9);
    finish_scn("strip");
    chk("strip_sym_is_1", 64'(sym_count), 64'd1);

    rdy_mode = 1;
    do_reset(3, 2);
    send_seq(1, 10, 9);
    finish_scn("backpressure");

    // Zero prefix, two back-to-back symbols.
    rdy_mode = 0;
    do_reset(3, 0);
    send_seq(1, 8, 7);
    send_seq(9, 8, 7);
    finish_scn("zero_cp");
    chk("zero_cp_sym_is_2", 64'(sym_count), 64'd2);

    // Early TLAST on sample 6, then a clean symbol 11..20.
    do_reset(3, 2);
    send_seq(1, 6, 5);
    send_seq(11, 10, 9);
    finish_scn("early_tlast");

    // Prefix length changed 2->4 mid-symbol takes effect on the next symbol.
    do_reset(3, 2);
    send_seq(1, 5, -1);
    cfg_cp = 12'd4;
    send_seq(6, 5, 4);
    send_seq(101, 12, 11);
    finish_scn("cfg_change");

    // Missing TLAST still completes the symbol.
    do_reset(3, 2);
    send_seq(1, 10, -1);
    send_seq(51, 10, 9);
    finish_scn("missing_tlast");

    // Illegal config: log2=2 clamps to 3, cp=9 clamps to 7.
    do_reset(2, 9);
    send_seq(1, 15, 14);
    finish_scn("clamp");

    // Reset after 5 forwarded samples drops the partial symbol.
    do_reset(3, 2);
    send_seq(1, 7, -1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("midrst_sym_count", 64'(sym_count), 64'd0);
    do_reset(3, 2);
    send_seq(21, 10, 9);
    finish_scn("after_reset");

    // Randomized segments with random gaps, ready and framing errors.
    for (int seg = 0; seg < 4; seg++) begin
      lg = (seg == 3) ? 13 : $urandom_range(0, 6);
      cp = (seg == 3) ? 3000 : $urandom_range(0, 40);
      rdy_mode = 2; gap_pct = 20;
      do_reset(lg, cp);
      sym_cfg(lg, cp, n, c);
      len = n + c;
      for (int s = 0; s < ((seg == 3) ? 1 : 4); s++) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          at = $urandom_range(0, len - 2);
          for (int k = 0; k <= at; k++) send($urandom, k == at);
        end else begin
          for (int k = 0; k < len; k++) send($urandom, (r != 1) && (k == len - 1));
        end
      end
      finish_scn($sformatf("rand%0d", seg));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
